// File: rtl/seven_seg_pkg.sv
// Shared segment bit positions and active-low glyph codes for the
// seven-segment display path.
package seven_seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_A     = 7'h08;
  localparam logic [6:0] GLYPH_B     = 7'h03;
  localparam logic [6:0] GLYPH_C     = 7'h46;
  localparam logic [6:0] GLYPH_D     = 7'h21;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_F     = 7'h0E;
  localparam logic [6:0] GLYPH_DASH  = 7'h3F;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

endpackage

// File: rtl/seven_seg_glyph.sv
// Combinational nibble-to-glyph lookup; codes above 9 become A-F or a
// dash depending on hex_mode_i.
module seven_seg_glyph
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_mode_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    glyph_o = GLYPH_BLANK;
    case (nibble_i)
      4'h0: glyph_o = GLYPH_0;
      4'h1: glyph_o = GLYPH_1;
      4'h2: glyph_o = GLYPH_2;
      4'h3: glyph_o = GLYPH_3;
      4'h4: glyph_o = GLYPH_4;
      4'h5: glyph_o = GLYPH_5;
      4'h6: glyph_o = GLYPH_6;
      4'h7: glyph_o = GLYPH_7;
      4'h8: glyph_o = GLYPH_8;
      4'h9: glyph_o = GLYPH_9;
      4'hA: glyph_o = hex_mode_i ? GLYPH_A : GLYPH_DASH;
      4'hB: glyph_o = hex_mode_i ? GLYPH_B : GLYPH_DASH;
      4'hC: glyph_o = hex_mode_i ? GLYPH_C : GLYPH_DASH;
      4'hD: glyph_o = hex_mode_i ? GLYPH_D : GLYPH_DASH;
      4'hE: glyph_o = hex_mode_i ? GLYPH_E : GLYPH_DASH;
      4'hF: glyph_o = hex_mode_i ? GLYPH_F : GLYPH_DASH;
      default: glyph_o = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode display driver: snapshot registers,
// prescaled digit scan, leading-zero blanking and a dead cycle per advance.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int SCAN_DIV         = 50000,
  parameter int HEX_MODE         = 0,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [4*NUM_DIGITS-1:0] Digits,
  input  logic [NUM_DIGITS-1:0]   DpIn,
  input  logic                    Load,
  input  logic                    LzbEn,
  output logic [6:0]              SevenSegs,
  output logic                    DpOut,
  output logic [NUM_DIGITS-1:0]   Anodes,
  output logic                    ScanTick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [NUM_DIGITS-1:0] ANODES_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic                    lzb_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q;

  logic                    tick;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [3:0]              sel_nib;
  logic                    sel_dp;
  logic                    sel_blank;
  logic                    run_zero;
  logic [6:0]              glyph;

  assign tick = (cnt_q == CNT_W'(SCAN_DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Walk from the most significant digit down; a digit blanks only while
  // everything at or above it is still zero.
  always_comb begin
    run_zero = 1'b1;
    blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero = run_zero & (digits_q[4*i +: 4] == 4'd0);
      if (i > 0) blank[i] = lzb_q & run_zero;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
      assign an_sel[gi] = (idx_q == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    sel_nib   = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_sel[i]) begin
        sel_nib   = digits_q[4*i +: 4];
        sel_dp    = dp_q[i];
        sel_blank = blank[i];
      end
    end
  end

  seven_seg_glyph u_glyph (
    .nibble_i   (sel_nib),
    .hex_mode_i (HEX_MODE != 0),
    .glyph_o    (glyph)
  );

  always_comb begin
    seg_d    = GLYPH_BLANK;
    dp_out_d = 1'b1;
    an_d     = ANODES_OFF;
    if (!tick) begin
      seg_d    = sel_blank ? GLYPH_BLANK : glyph;
      dp_out_d = ~sel_dp;
      an_d     = an_sel ^ ANODES_OFF;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      digits_q <= '0;
      dp_q     <= '0;
      lzb_q    <= 1'b0;
      seg_q    <= GLYPH_BLANK;
      dp_out_q <= 1'b1;
      an_q     <= ANODES_OFF;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      dp_out_q <= dp_out_d;
      an_q     <= an_d;
      tick_q   <= tick;
      if (Load) begin
        digits_q <= Digits;
        dp_q     <= DpIn;
        lzb_q    <= LzbEn;
      end
    end
  end

  assign SevenSegs = seg_q;
  assign DpOut     = dp_out_q;
  assign Anodes    = an_q;
  assign ScanTick  = tick_q;

endmodule
